// File: rtl/foh_interp_seq.sv
// First-order-hold interpolation sequencer: forms the sample delta, has an external
// universal shift register divide it by L, then emits L linear steps per input sample.
module foh_interp_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2_L     = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [2:0]            SR_S,
    output logic [DATA_WIDTH-1:0] SR_D,
    input  logic [DATA_WIDTH-1:0] SR_Q
);

    localparam int IDX_W = (LOG2_L > 0) ? LOG2_L : 1;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << LOG2_L) - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((LOG2_L > 0) ? (LOG2_L - 1) : 0);
    localparam logic [2:0] SR_HOLD = 3'd0;
    localparam logic [2:0] SR_LOAD = 3'd1;
    localparam logic [2:0] SR_ASR  = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_EMIT    = 3'd4
    } state_t;

    // Difference taken one bit wider, then clamped to the representable range.
    function automatic logic [DATA_WIDTH-1:0] sat_sub(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH:0] d;
        d = {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};
        if (d[DATA_WIDTH] != d[DATA_WIDTH-1]) begin
            sat_sub = d[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                    : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            sat_sub = d[DATA_WIDTH-1:0];
        end
    endfunction

    state_t                state_r, state_s;
    logic [DATA_WIDTH-1:0] prev_r, prev_s;
    logic [DATA_WIDTH-1:0] base_r, base_s;
    logic [DATA_WIDTH-1:0] step_r, step_s;
    logic [DATA_WIDTH-1:0] acc_r, acc_s;
    logic [IDX_W-1:0]      idx_r, idx_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic                  in_ready_r, in_ready_s;
    logic                  out_valid_r, out_valid_s;
    logic [2:0]            sr_s_r, sr_s_s;
    logic [DATA_WIDTH-1:0] sr_d_r, sr_d_s;

    // Next-state and datapath updates; outputs are decoded from the next state so they register with it.
    always_comb begin
        state_s  = state_r;
        prev_s   = prev_r;
        base_s   = base_r;
        step_s   = step_r;
        acc_s    = acc_r;
        idx_s    = idx_r;
        cnt_s    = cnt_r;
        sr_d_s   = sr_d_r;
        case (state_r)
            ST_IDLE: begin
                if (IN_VALID && in_ready_r) begin
                    // The delta lives in the SR_D register until the load completes.
                    sr_d_s  = sat_sub(IN_DATA, prev_r);
                    base_s  = prev_r;
                    prev_s  = IN_DATA;
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                cnt_s   = {CNT_W{1'b0}};
                state_s = (LOG2_L > 0) ? ST_SHIFT : ST_CAPTURE;
            end
            ST_SHIFT: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = ST_CAPTURE;
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                step_s  = SR_Q;
                acc_s   = base_r;
                idx_s   = {IDX_W{1'b0}};
                state_s = ST_EMIT;
            end
            ST_EMIT: begin
                if (out_valid_r && OUT_READY) begin
                    acc_s   = acc_r + step_r;
                    idx_s   = idx_r + IDX_W'(1);
                    state_s = (idx_r == IDX_LAST) ? ST_IDLE : ST_EMIT;
                end else begin
                    state_s = ST_EMIT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        in_ready_s  = (state_s == ST_IDLE);
        out_valid_s = (state_s == ST_EMIT);
        case (state_s)
            ST_LOAD:  sr_s_s = SR_LOAD;
            ST_SHIFT: sr_s_s = SR_ASR;
            default:  sr_s_s = SR_HOLD;
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= ST_IDLE;
            prev_r      <= {DATA_WIDTH{1'b0}};
            base_r      <= {DATA_WIDTH{1'b0}};
            step_r      <= {DATA_WIDTH{1'b0}};
            acc_r       <= {DATA_WIDTH{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            sr_s_r      <= SR_HOLD;
            sr_d_r      <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r     <= state_s;
            prev_r      <= prev_s;
            base_r      <= base_s;
            step_r      <= step_s;
            acc_r       <= acc_s;
            idx_r       <= idx_s;
            cnt_r       <= cnt_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            sr_s_r      <= sr_s_s;
            sr_d_r      <= sr_d_s;
        end
    end

    assign IN_READY  = in_ready_r;
    assign OUT_VALID = out_valid_r;
    assign OUT_DATA  = acc_r;
    assign SR_S      = sr_s_r;
    assign SR_D      = sr_d_r;

endmodule

// File: tb/tb_foh_interp_seq.sv
// Scoreboard bench for foh_interp_seq: one instance with L=4, one with L=1, each
// paired with a behavioural universal shift register.
module tb_foh_interp_seq;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [DW-1:0] in_data2, out_data2, sr_d2, sr_q2;
    logic          in_valid2, in_ready2, out_valid2, out_ready2;
    logic [2:0]    sr_s2;
    logic [DW-1:0] in_data0, out_data0, sr_d0, sr_q0;
    logic          in_valid0, in_ready0, out_valid0, out_ready0;
    logic [2:0]    sr_s0;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp2[$];
    logic [DW-1:0] exp0[$];

    logic [2:0] seq_sr [2][5] = '{'{3'd1, 3'd6, 3'd6, 3'd0, 3'd0}, '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0}};
    logic       seq_ov [2][5] = '{'{1'b0, 1'b0, 1'b0, 1'b0, 1'b1}, '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};

    foh_interp_seq #(.DATA_WIDTH(DW), .LOG2_L(2)) dut2 (
        .CLK(clk), .RST(rst), .IN_DATA(in_data2), .IN_VALID(in_valid2), .IN_READY(in_ready2),
        .OUT_DATA(out_data2), .OUT_VALID(out_valid2), .OUT_READY(out_ready2),
        .SR_S(sr_s2), .SR_D(sr_d2), .SR_Q(sr_q2)
    );

    foh_interp_seq #(.DATA_WIDTH(DW), .LOG2_L(0)) dut0 (
        .CLK(clk), .RST(rst), .IN_DATA(in_data0), .IN_VALID(in_valid0), .IN_READY(in_ready0),
        .OUT_DATA(out_data0), .OUT_VALID(out_valid0), .OUT_READY(out_ready0),
        .SR_S(sr_s0), .SR_D(sr_d0), .SR_Q(sr_q0)
    );

    // Behavioural shift registers: 1 load, 6 arithmetic right shift, otherwise hold.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q2 <= '0;
            sr_q0 <= '0;
        end else begin
            case (sr_s2)
                3'd1:    sr_q2 <= sr_d2;
                3'd6:    sr_q2 <= {sr_q2[DW-1], sr_q2[DW-1:1]};
                default: sr_q2 <= sr_q2;
            endcase
            case (sr_s0)
                3'd1:    sr_q0 <= sr_d0;
                3'd6:    sr_q0 <= {sr_q0[DW-1], sr_q0[DW-1:1]};
                default: sr_q0 <= sr_q0;
            endcase
        end
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, $signed(act), $signed(exp), $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitors: every accepted output is matched against the head of its queue.
    always @(negedge clk) begin
        if (!rst && out_valid2 && out_ready2) begin
            if (exp2.size() == 0) fail_now("out2_unexpected");
            else check("out2", out_data2, exp2.pop_front());
        end
        if (!rst && out_valid0 && out_ready0) begin
            if (exp0.size() == 0) fail_now("out0_unexpected");
            else check("out0", out_data0, exp0.pop_front());
        end
    end

    task automatic push4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c, input logic [DW-1:0] d);
        exp2.push_back(a); exp2.push_back(b); exp2.push_back(c); exp2.push_back(d);
    endtask

    // sel=0 drives the L=4 instance, sel=1 the L=1 instance; seq checks SR_S/OUT_VALID timing.
    task automatic send(input bit sel, input logic [DW-1:0] v, input bit seq);
        int n;
        n = 0;
        @(posedge clk); #1;
        if (sel) begin in_data0 = v; in_valid0 = 1'b1; end
        else     begin in_data2 = v; in_valid2 = 1'b1; end
        do begin
            @(negedge clk);
            n++;
        end while (!(sel ? in_ready0 : in_ready2) && n < 200);
        if (!(sel ? in_ready0 : in_ready2)) begin
            fail_now("in_ready_timeout");
            in_valid0 = 1'b0;
            in_valid2 = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        in_valid2 = 1'b0;
        if (seq) begin
            for (int k = 0; k < (sel ? 3 : 5); k++) begin
                @(negedge clk);
                check("sr_s_seq", DW'(sel ? sr_s0 : sr_s2), DW'(seq_sr[sel][k]));
                check("out_valid_seq", DW'(sel ? out_valid0 : out_valid2), DW'(seq_ov[sel][k]));
                check("in_ready_busy", DW'(sel ? in_ready0 : in_ready2), DW'(1'b0));
            end
        end
    endtask

    task automatic wait_idle(input bit sel);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sel ? in_ready0 : in_ready2) && n < 200);
        check("in_ready_back", DW'(sel ? in_ready0 : in_ready2), DW'(1'b1));
    endtask

    // Returns on the falling edge where the cnt-th handshake of the L=4 instance is pending.
    task automatic wait_hs2(input int cnt);
        int n, hs;
        n = 0;
        hs = 0;
        while (hs < cnt && n < 200) begin
            @(negedge clk);
            n++;
            if (out_valid2 && out_ready2) hs++;
        end
        if (hs < cnt) fail_now("handshake_timeout");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        in_data2 = '0; in_valid2 = 1'b0; out_ready2 = 1'b1;
        in_data0 = '0; in_valid0 = 1'b0; out_ready0 = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", DW'(in_ready2), DW'(1'b1));
        check("rst_out_valid", DW'(out_valid2), DW'(1'b0));
        check("rst_out_data", out_data2, 16'd0);
        check("rst_sr_s", DW'(sr_s2), DW'(3'd0));
        check("rst_sr_d", sr_d2, 16'd0);
        check("rst_out_valid0", DW'(out_valid0), DW'(1'b0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic ramps, floor rounding, and saturation of the delta.
        push4(16'sd0, 16'sd25, 16'sd50, 16'sd75);
        send(1'b0, 16'sd100, 1'b1);
        push4(16'sd100, 16'sd80, 16'sd60, 16'sd40);
        send(1'b0, 16'sd20, 1'b0);
        push4(16'sd20, 16'sd18, 16'sd16, 16'sd14);
        send(1'b0, 16'sd13, 1'b0);
        push4(16'sd13, 16'sd8201, 16'sd16389, 16'sd24577);
        send(1'b0, 16'sd32767, 1'b0);
        push4(16'sd32767, 16'sd24575, 16'sd16383, 16'sd8191);
        send(1'b0, 16'h8000, 1'b0);

        // Backpressure: delta saturates to +32767, step 8191; stall with the second value shown.
        push4(16'h8000, -16'sd24577, -16'sd16386, -16'sd8195);
        send(1'b0, 16'sd0, 1'b0);
        wait_hs2(1);
        @(posedge clk); #1;
        out_ready2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_out_data", out_data2, -16'sd24577);
            check("bp_out_valid", DW'(out_valid2), DW'(1'b1));
            check("bp_in_ready", DW'(in_ready2), DW'(1'b0));
        end
        @(posedge clk); #1;
        out_ready2 = 1'b1;
        wait_idle(1'b0);
        check("bp_queue_empty", DW'(exp2.size()), 16'd0);

        // Reset between outputs discards the segment; next sample ramps from zero.
        exp2.push_back(16'sd0);
        exp2.push_back(16'sd10);
        send(1'b0, 16'sd40, 1'b0);
        wait_hs2(2);
        @(posedge clk); #1;
        out_ready2 = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", DW'(out_valid2), DW'(1'b0));
        check("rst_mid_out_data", out_data2, 16'd0);
        check("rst_mid_in_ready", DW'(in_ready2), DW'(1'b1));
        check("rst_mid_queue", DW'(exp2.size()), 16'd0);
        exp2.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready2 = 1'b1;
        push4(16'sd0, 16'sd12, 16'sd24, 16'sd36);
        send(1'b0, 16'sd50, 1'b0);
        wait_idle(1'b0);
        check("post_rst_queue", DW'(exp2.size()), 16'd0);

        // L=1: one output per sample, equal to the previous sample.
        exp0.push_back(16'sd0);
        send(1'b1, 16'sd7, 1'b1);
        exp0.push_back(16'sd7);
        send(1'b1, 16'sd9, 1'b0);
        wait_idle(1'b1);
        check("l1_queue_empty", DW'(exp0.size()), 16'd0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
